bypass_ctrl: RTL and testbench

- Producer side of the dual-lane operand-forwarding interface.
- Carries destination-register tags for both issue lanes through EXEC -> LSU -> WB.
- Drives the per-stage write-valid/address pairs (wm*/am*, ww*/aw*) that the forwarding muxes consume.
- Generates the load-use stall, since a load result cannot be forwarded into the instruction directly behind it.
- Masks stale tags so that a fixed forwarding priority (LSU0 > WB0 > LSU1 > WB1) always selects the youngest producer.

---
 rtl/bypass_ctrl.sv | 114 +++++++++++
 tb/tb_bypass_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bypass_ctrl.sv
// rtl/bypass_ctrl.sv - dual-lane destination-tag pipeline, youngest-wins forwarding valids and load-use stall
// Optional stall counter output when BYPASS_CTRL_STALL_CNT_EN is defined.
module bypass_ctrl #(
    parameter int RA_W        = 5,
    parameter int STALL_CNT_W = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            hold_i,
    input  logic            flush_i,
    input  logic            id_valid0_i,
    input  logic            id_valid1_i,
    input  logic            id_we0_i,
    input  logic            id_we1_i,
    input  logic            id_load0_i,
    input  logic            id_load1_i,
    input  logic [RA_W-1:0] id_rd0_i,
    input  logic [RA_W-1:0] id_rd1_i,
    input  logic            r0_1_i,
    input  logic            r0_2_i,
    input  logic            r1_1_i,
    input  logic            r1_2_i,
    input  logic [RA_W-1:0] a0_1_i,
    input  logic [RA_W-1:0] a0_2_i,
    input  logic [RA_W-1:0] a1_1_i,
    input  logic [RA_W-1:0] a1_2_i,
    output logic            wm0_o,
    output logic            wm1_o,
    output logic [RA_W-1:0] am0_o,
    output logic [RA_W-1:0] am1_o,
    output logic            ww0_o,
    output logic            ww1_o,
    output logic [RA_W-1:0] aw0_o,
    output logic [RA_W-1:0] aw1_o,
    output logic            stall_o
`ifdef BYPASS_CTRL_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
`endif
);

    localparam int TW  = RA_W + 2;
    localparam int WE  = RA_W + 1;
    localparam int LD  = RA_W;

    logic [TW-1:0] e0, e1, m0, m1, w0, w1;
    logic [TW-1:0] d0, d1;
    logic          we0_q, we1_q;

    // A write to x0 never becomes a tag, so it can never be forwarded or stall.
    assign we0_q = id_valid0_i & id_we0_i & (id_rd0_i != '0);
    assign we1_q = id_valid1_i & id_we1_i & (id_rd1_i != '0);
    assign d0    = {we0_q, id_valid0_i & id_load0_i, id_rd0_i};
    assign d1    = {we1_q, id_valid1_i & id_load1_i, id_rd1_i};

    function automatic logic load_hit(input logic r, input logic [RA_W-1:0] a,
                                      input logic [TW-1:0] t0, input logic [TW-1:0] t1);
        load_hit = r & (a != '0) &
                   ((t0[WE] & t0[LD] & (t0[RA_W-1:0] == a)) |
                    (t1[WE] & t1[LD] & (t1[RA_W-1:0] == a)));
    endfunction

    // Deliberately ignores a younger non-load write to the same rd in E1.
    assign stall_o = !flush_i & (load_hit(r0_1_i, a0_1_i, e0, e1) |
                                 load_hit(r0_2_i, a0_2_i, e0, e1) |
                                 load_hit(r1_1_i, a1_1_i, e0, e1) |
                                 load_hit(r1_2_i, a1_2_i, e0, e1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            e0 <= '0;
            e1 <= '0;
            m0 <= '0;
            m1 <= '0;
            w0 <= '0;
            w1 <= '0;
        end else if (!hold_i) begin
            w0 <= m0;
            w1 <= m1;
            m0 <= e0;
            m1 <= e1;
            if (flush_i || stall_o) begin
                e0 <= '0;
                e1 <= '0;
            end else begin
                e0 <= d0;
                e1 <= d1;
            end
        end
    end

    // Mask older producers shadowed by a younger one so the fixed mux priority picks the youngest.
    assign wm1_o = m1[WE];
    assign wm0_o = m0[WE] & !(m1[WE] & (m1[RA_W-1:0] == m0[RA_W-1:0]));
    assign ww1_o = w1[WE] & !((m0[WE] & (m0[RA_W-1:0] == w1[RA_W-1:0])) |
                              (m1[WE] & (m1[RA_W-1:0] == w1[RA_W-1:0])));
    assign ww0_o = w0[WE] & !((w1[WE] & (w1[RA_W-1:0] == w0[RA_W-1:0])) |
                              (m0[WE] & (m0[RA_W-1:0] == w0[RA_W-1:0])) |
                              (m1[WE] & (m1[RA_W-1:0] == w0[RA_W-1:0])));
    assign am0_o = m0[RA_W-1:0];
    assign am1_o = m1[RA_W-1:0];
    assign aw0_o = w0[RA_W-1:0];
    assign aw1_o = w1[RA_W-1:0];

`ifdef BYPASS_CTRL_STALL_CNT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            stall_cnt_o <= '0;
        else if (stall_o && !hold_i)
            stall_cnt_o <= stall_cnt_o + 1'b1;
    end
`endif

endmodule

// File: tb/tb_bypass_ctrl.sv
// tb/tb_bypass_ctrl.sv - directed self-checking bench for bypass_ctrl
module tb_bypass_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_n_i, hold_i, flush_i;
    logic       id_valid0_i, id_valid1_i, id_we0_i, id_we1_i, id_load0_i, id_load1_i;
    logic [4:0] id_rd0_i, id_rd1_i;
    logic       r0_1_i, r0_2_i, r1_1_i, r1_2_i;
    logic [4:0] a0_1_i, a0_2_i, a1_1_i, a1_2_i;
    logic       wm0_o, wm1_o, ww0_o, ww1_o, stall_o;
    logic [4:0] am0_o, am1_o, aw0_o, aw1_o;
`ifdef BYPASS_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int compared = 0;
    int mismatched = 0;

    logic [3:0]  vld;
    logic [19:0] adr;
    assign vld = {wm0_o, wm1_o, ww0_o, ww1_o};
    assign adr = {am0_o, am1_o, aw0_o, aw1_o};

    bypass_ctrl #(.RA_W(5), .STALL_CNT_W(32)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .hold_i(hold_i), .flush_i(flush_i),
        .id_valid0_i(id_valid0_i), .id_valid1_i(id_valid1_i),
        .id_we0_i(id_we0_i), .id_we1_i(id_we1_i),
        .id_load0_i(id_load0_i), .id_load1_i(id_load1_i),
        .id_rd0_i(id_rd0_i), .id_rd1_i(id_rd1_i),
        .r0_1_i(r0_1_i), .r0_2_i(r0_2_i), .r1_1_i(r1_1_i), .r1_2_i(r1_2_i),
        .a0_1_i(a0_1_i), .a0_2_i(a0_2_i), .a1_1_i(a1_1_i), .a1_2_i(a1_2_i),
        .wm0_o(wm0_o), .wm1_o(wm1_o), .am0_o(am0_o), .am1_o(am1_o),
        .ww0_o(ww0_o), .ww1_o(ww1_o), .aw0_o(aw0_o), .aw1_o(aw1_o),
        .stall_o(stall_o)
`ifdef BYPASS_CTRL_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        id_valid0_i = 0; id_valid1_i = 0; id_we0_i = 0; id_we1_i = 0;
        id_load0_i = 0; id_load1_i = 0; id_rd0_i = 0; id_rd1_i = 0;
        r0_1_i = 0; r0_2_i = 0; r1_1_i = 0; r1_2_i = 0;
        a0_1_i = 0; a0_2_i = 0; a1_1_i = 0; a1_2_i = 0;
        flush_i = 0; hold_i = 0;
    endtask

    task automatic lane0(input logic ld, input logic [4:0] rd);
        id_valid0_i = 1; id_we0_i = 1; id_load0_i = ld; id_rd0_i = rd;
    endtask

    task automatic lane1(input logic ld, input logic [4:0] rd);
        id_valid1_i = 1; id_we1_i = 1; id_load1_i = ld; id_rd1_i = rd;
    endtask

    task automatic do_reset();
        idle();
        rst_n_i = 0;
        tick();
        tick();
        rst_n_i = 1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n_i = 0;
        #12;
        compared++;
        if ({vld, adr, stall_o} !== 25'd0) begin
            mismatched++;
            $display("FAIL reset_low: outputs=%h expected 0", {vld, adr, stall_o});
        end
        rst_n_i = 1;
        tick();
        compared++;
        if ({vld, adr, stall_o} !== 25'd0) begin
            mismatched++;
            $display("FAIL reset_release: outputs=%h expected 0", {vld, adr, stall_o});
        end
    endtask

    task automatic test_basic();
        do_reset();
        lane0(0, 5'd5);
        tick();
        idle();
        tick();
        compared++;
        if (vld !== 4'b1000 || am0_o !== 5'd5) begin
            mismatched++;
            $display("FAIL basic_m: vld=%b am0=%0d expected 1000/5", vld, am0_o);
        end
        tick();
        compared++;
        if (vld !== 4'b0010 || aw0_o !== 5'd5) begin
            mismatched++;
            $display("FAIL basic_w: vld=%b aw0=%0d expected 0010/5", vld, aw0_o);
        end
        tick();
        compared++;
        if (vld !== 4'b0000) begin
            mismatched++;
            $display("FAIL basic_drain: vld=%b expected 0000", vld);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        lane0(1, 5'd7);
        tick();
        idle();
        r1_2_i = 1; a1_2_i = 5'd7;
        lane1(0, 5'd8);
        #1;
        compared++;
        if (stall_o !== 1'b1) begin
            mismatched++;
            $display("FAIL load_use_stall: stall=%b expected 1", stall_o);
        end
        tick();
        compared++;
        if (stall_o !== 1'b0 || wm0_o !== 1'b1 || am0_o !== 5'd7 || wm1_o !== 1'b0) begin
            mismatched++;
            $display("FAIL load_use_next: stall=%b wm0=%b am0=%0d wm1=%b expected 0/1/7/0",
                     stall_o, wm0_o, am0_o, wm1_o);
        end
        idle();
        tick();
        compared++;
        if (wm1_o !== 1'b0 || ww0_o !== 1'b1) begin
            mismatched++;
            $display("FAIL load_use_bubble: wm1=%b ww0=%b expected 0/1", wm1_o, ww0_o);
        end
        // conservative: younger non-load write of 7 in E1 does not cancel the stall
        do_reset();
        lane0(1, 5'd7);
        lane1(0, 5'd7);
        tick();
        idle();
        r0_1_i = 1; a0_1_i = 5'd7;
        #1;
        compared++;
        if (stall_o !== 1'b1) begin
            mismatched++;
            $display("FAIL load_use_conservative: stall=%b expected 1", stall_o);
        end
        r0_1_i = 0;
        #1;
        compared++;
        if (stall_o !== 1'b0) begin
            mismatched++;
            $display("FAIL load_use_noread: stall=%b expected 0", stall_o);
        end
    endtask

    task automatic test_masking();
        do_reset();
        lane0(0, 5'd3);
        lane1(0, 5'd3);
        tick();
        idle();
        tick();
        compared++;
        if (vld !== 4'b0100 || am0_o !== 5'd3 || am1_o !== 5'd3) begin
            mismatched++;
            $display("FAIL mask_m_same: vld=%b am0=%0d am1=%0d expected 0100/3/3", vld, am0_o, am1_o);
        end
        tick();
        compared++;
        if (vld !== 4'b0001 || aw0_o !== 5'd3) begin
            mismatched++;
            $display("FAIL mask_w_same: vld=%b aw0=%0d expected 0001/3", vld, aw0_o);
        end
        do_reset();
        lane0(0, 5'd0);
        tick();
        idle();
        tick();
        compared++;
        if (vld !== 4'b0000) begin
            mismatched++;
            $display("FAIL x0_m: vld=%b expected 0000", vld);
        end
        tick();
        compared++;
        if (vld !== 4'b0000) begin
            mismatched++;
            $display("FAIL x0_w: vld=%b expected 0000", vld);
        end
        do_reset();
        lane0(0, 5'd9);
        tick();
        idle();
        lane1(0, 5'd9);
        tick();
        idle();
        tick();
        compared++;
        if (vld !== 4'b0100 || aw0_o !== 5'd9 || am1_o !== 5'd9) begin
            mismatched++;
            $display("FAIL mask_m1_w0: vld=%b aw0=%0d am1=%0d expected 0100/9/9", vld, aw0_o, am1_o);
        end
        do_reset();
        lane0(0, 5'd9);
        tick();
        lane0(0, 5'd4);
        tick();
        idle();
        tick();
        compared++;
        if (vld !== 4'b1010 || aw0_o !== 5'd9 || am0_o !== 5'd4) begin
            mismatched++;
            $display("FAIL nomask_w0: vld=%b aw0=%0d am0=%0d expected 1010/9/4", vld, aw0_o, am0_o);
        end
    endtask

    task automatic test_flush();
        do_reset();
        lane0(1, 5'd7);
        tick();
        idle();
        lane0(0, 5'd6);
        r0_1_i = 1; a0_1_i = 5'd7;
        flush_i = 1;
        #1;
        compared++;
        if (stall_o !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_stall: stall=%b expected 0", stall_o);
        end
        tick();
        idle();
        compared++;
        if (wm0_o !== 1'b1 || am0_o !== 5'd7) begin
            mismatched++;
            $display("FAIL flush_m: wm0=%b am0=%0d expected 1/7", wm0_o, am0_o);
        end
        tick();
        compared++;
        if (vld !== 4'b0010) begin
            mismatched++;
            $display("FAIL flush_squash: vld=%b expected 0010", vld);
        end
    endtask

    task automatic test_hold();
        do_reset();
        lane0(0, 5'd5);
        tick();
        idle();
        lane1(0, 5'd6);
        tick();
        idle();
        hold_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (vld !== 4'b1000 || am0_o !== 5'd5) begin
                mismatched++;
                $display("FAIL hold_frozen%0d: vld=%b am0=%0d expected 1000/5", i, vld, am0_o);
            end
        end
        hold_i = 0;
        tick();
        compared++;
        if (vld !== 4'b0110 || aw0_o !== 5'd5 || am1_o !== 5'd6) begin
            mismatched++;
            $display("FAIL hold_resume1: vld=%b aw0=%0d am1=%0d expected 0110/5/6", vld, aw0_o, am1_o);
        end
        tick();
        compared++;
        if (vld !== 4'b0001 || aw1_o !== 5'd6) begin
            mismatched++;
            $display("FAIL hold_resume2: vld=%b aw1=%0d expected 0001/6", vld, aw1_o);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            lane0(0, 5'(2 * i + 1));
            lane1(0, 5'(2 * i + 2));
            tick();
        end
        idle();
        r0_1_i = 1; a0_1_i = 5'd5;
        #1;
        compared++;
        if (vld !== 4'b1111) begin
            mismatched++;
            $display("FAIL full_pipe: vld=%b expected 1111", vld);
        end
        #2;
        rst_n_i = 0;
        #1;
        compared++;
        if ({vld, adr, stall_o} !== 25'd0) begin
            mismatched++;
            $display("FAIL async_reset: outputs=%h expected 0", {vld, adr, stall_o});
        end
        #2;
        rst_n_i = 1;
        idle();
        tick();
        compared++;
        if ({vld, adr, stall_o} !== 25'd0) begin
            mismatched++;
            $display("FAIL async_reset_after: outputs=%h expected 0", {vld, adr, stall_o});
        end
    endtask

`ifdef BYPASS_CTRL_STALL_CNT_EN
    task automatic test_stall_cnt();
        do_reset();
        compared++;
        if (stall_cnt_o !== 32'd0) begin
            mismatched++;
            $display("FAIL cnt_reset: cnt=%0d expected 0", stall_cnt_o);
        end
        for (int i = 0; i < 3; i++) begin
            lane0(1, 5'd7);
            tick();
            idle();
            r0_2_i = 1; a0_2_i = 5'd7;
            tick();
            idle();
        end
        compared++;
        if (stall_cnt_o !== 32'd3) begin
            mismatched++;
            $display("FAIL cnt_three: cnt=%0d expected 3", stall_cnt_o);
        end
        lane0(1, 5'd7);
        tick();
        idle();
        r0_2_i = 1; a0_2_i = 5'd7;
        hold_i = 1;
        tick();
        compared++;
        if (stall_cnt_o !== 32'd3 || stall_o !== 1'b1) begin
            mismatched++;
            $display("FAIL cnt_hold: cnt=%0d stall=%b expected 3/1", stall_cnt_o, stall_o);
        end
        idle();
    endtask
`endif

    initial begin
        idle();
        rst_n_i = 1;
        test_reset();
        test_basic();
        test_load_use();
        test_masking();
        test_flush();
        test_hold();
        test_async_reset();
`ifdef BYPASS_CTRL_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
